// File: rtl/puf_readout_host.sv
// PUF readout initiator: sends the dump command over UART, collects the response bytes.
// Define PUF_HOST_CRC_EN to add a CRC-8 (poly 0x07) output over the response bytes.
module puf_readout_host #(
    parameter int         PUF_BITS       = 131072,
    parameter logic [7:0] CMD_BYTE       = 8'h73,
    parameter int         TIMEOUT_CYCLES = 1000000,
    localparam int        NBYTES         = PUF_BITS / 8,
    localparam int        BCW            = $clog2(NBYTES + 1),
    localparam int        HWW            = $clog2(PUF_BITS + 1)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           timeout_err,
    input  logic           uart_tx_ready,
    output logic           uart_tx_enable,
    output logic [7:0]     uart_data_to_tx,
    input  logic           uart_rx_ready,
    input  logic [7:0]     uart_data_from_rx,
    output logic           rx_byte_valid,
    output logic [7:0]     rx_byte,
`ifdef PUF_HOST_CRC_EN
    output logic [7:0]     crc8,
`endif
    output logic [BCW-1:0] byte_count,
    output logic [HWW-1:0] hamming_weight
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BCW-1:0] LAST_IDX = BCW'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        RECV,
        DONE,
        ERROR
    } state_t;

    state_t state_q, state_d;
    logic [TW-1:0] timer;

    logic go, send, got, last, expire;

    assign go     = (state_q == IDLE) && start;
    assign send   = (state_q == SEND) && uart_tx_ready;
    assign got    = (state_q == RECV) && uart_rx_ready;
    assign last   = got && (byte_count == LAST_IDX);
    // A byte arriving on the final timer cycle takes priority over the timeout.
    assign expire = (state_q == RECV) && !uart_rx_ready && (timer == TMAX);
    assign done   = (state_q == DONE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SEND;
            SEND:    if (uart_tx_ready) state_d = RECV;
            RECV: begin
                if (last)        state_d = DONE;
                else if (expire) state_d = ERROR;
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
            uart_tx_enable  <= 1'b0;
            uart_data_to_tx <= 8'h00;
            rx_byte_valid   <= 1'b0;
            rx_byte         <= 8'h00;
            byte_count      <= '0;
            hamming_weight  <= '0;
            timer           <= '0;
        end else begin
            uart_tx_enable <= send;
            rx_byte_valid  <= got;
            if (go) begin
                busy           <= 1'b1;
                timeout_err    <= 1'b0;
                byte_count     <= '0;
                hamming_weight <= '0;
                timer          <= '0;
            end
            if (send) uart_data_to_tx <= CMD_BYTE;
            if (got) begin
                rx_byte        <= uart_data_from_rx;
                byte_count     <= byte_count + 1'b1;
                hamming_weight <= hamming_weight
                                + HWW'($countones(uart_data_from_rx));
                timer          <= '0;
            end else if (state_q == RECV) begin
                timer <= timer + 1'b1;
            end
            if (last) busy <= 1'b0;
            if (expire) begin
                timeout_err <= 1'b1;
                busy        <= 1'b0;
            end
        end
    end

`ifdef PUF_HOST_CRC_EN
    function automatic logic [7:0] crc_step(
        input logic [7:0] c,
        input logic [7:0] d
    );
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)      crc8 <= 8'h00;
        else if (go)  crc8 <= 8'h00;
        else if (got) crc8 <= crc_step(crc8, uart_data_from_rx);
    end
`endif

endmodule
